// File: rtl/nivel_comida_gen.sv
// Food level generator: timed decay, gated feed-button refill with cooldown, and a
// manual test mode that steps the level by hand.
module nivel_comida_gen #(
    parameter int unsigned DECAY_TICKS    = 250_000_000,
    parameter int unsigned COOLDOWN_TICKS = 25_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Boton_Comida,
    input  logic       Activo_Comida,
    input  logic       Senal_Test,
    input  logic       Senal_MTest,
    output logic [1:0] Nivel_Comida,
    output logic       Comida_Aceptada,
    output logic       Pulso_Decaimiento,
    output logic       En_Espera
);

    typedef enum logic {
        LISTO  = 1'b0,
        ESPERA = 1'b1
    } estado_t;

    localparam logic [CNT_W-1:0] DECAY_LAST = CNT_W'(DECAY_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

    function automatic logic [1:0] wrap_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd3 : v - 2'd1;
    endfunction

    logic             boton_p0, boton_p1, boton_p2;
    logic             test_p0, test_p1, test_p2;
    logic [CNT_W-1:0] decay_cnt;
    logic [CNT_W-1:0] cool_cnt;
    estado_t          estado;

    logic       boton_rise, test_rise;
    logic       decay_hit, accept, test_step;
    logic [1:0] nivel_next;

    // ---- stage p2: edge detect, decay expiry, feed acceptance ----
    always_comb begin
        boton_rise = boton_p1 & ~boton_p2;
        test_rise  = test_p1 & ~test_p2;
        decay_hit  = ~Senal_MTest && (decay_cnt == DECAY_LAST);
        accept     = (estado == LISTO) && boton_rise && Activo_Comida && ~Senal_MTest;
        test_step  = Senal_MTest && test_rise;

        // Feed and decay landing together cancel; test mode never accepts a feed.
        nivel_next = Nivel_Comida;
        if (test_step)
            nivel_next = wrap_dec(Nivel_Comida);
        else if (accept && !decay_hit)
            nivel_next = sat_inc(Nivel_Comida);
        else if (decay_hit && !accept)
            nivel_next = sat_dec(Nivel_Comida);
    end

    // ---- stages p0/p1: input synchronizers; p2: history; level and decay timer ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            boton_p0          <= 1'b0;
            boton_p1          <= 1'b0;
            boton_p2          <= 1'b0;
            test_p0           <= 1'b0;
            test_p1           <= 1'b0;
            test_p2           <= 1'b0;
            decay_cnt         <= '0;
            Nivel_Comida      <= 2'd3;
            Pulso_Decaimiento <= 1'b0;
        end else begin
            boton_p0          <= Boton_Comida;
            boton_p1          <= boton_p0;
            boton_p2          <= boton_p1;
            test_p0           <= Senal_Test;
            test_p1           <= test_p0;
            test_p2           <= test_p1;
            if (Senal_MTest || decay_hit)
                decay_cnt <= '0;
            else
                decay_cnt <= decay_cnt + CNT_ONE;
            Pulso_Decaimiento <= decay_hit;
            Nivel_Comida      <= nivel_next;
        end
    end

    // ---- feed FSM: cooldown keeps running regardless of test mode ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado          <= LISTO;
            cool_cnt        <= '0;
            Comida_Aceptada <= 1'b0;
            En_Espera       <= 1'b0;
        end else begin
            Comida_Aceptada <= accept;
            case (estado)
                LISTO: begin
                    if (accept) begin
                        estado    <= ESPERA;
                        cool_cnt  <= '0;
                        En_Espera <= 1'b1;
                    end
                end
                ESPERA: begin
                    if (cool_cnt == COOL_LAST) begin
                        estado    <= LISTO;
                        cool_cnt  <= '0;
                        En_Espera <= 1'b0;
                    end else begin
                        cool_cnt <= cool_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nivel_comida_gen.sv
// Directed bench for nivel_comida_gen with DECAY_TICKS=8, COOLDOWN_TICKS=4.
module tb_nivel_comida_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       Boton_Comida;
    logic       Activo_Comida;
    logic       Senal_Test;
    logic       Senal_MTest;
    logic [1:0] Nivel_Comida;
    logic       Comida_Aceptada;
    logic       Pulso_Decaimiento;
    logic       En_Espera;

    int total = 0;
    int bad   = 0;
    int acc_cnt;
    int dec_cnt;

    nivel_comida_gen #(
        .DECAY_TICKS   (8),
        .COOLDOWN_TICKS(4),
        .CNT_W         (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Boton_Comida     (Boton_Comida),
        .Activo_Comida    (Activo_Comida),
        .Senal_Test       (Senal_Test),
        .Senal_MTest      (Senal_MTest),
        .Nivel_Comida     (Nivel_Comida),
        .Comida_Aceptada  (Comida_Aceptada),
        .Pulso_Decaimiento(Pulso_Decaimiento),
        .En_Espera        (En_Espera)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle manual step pulse; returns just after the edge where it takes effect.
    task automatic press_test();
        Senal_Test = 1'b1;
        tick();
        Senal_Test = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_steps [5];
        exp_steps = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2};

        reset         = 1'b0;
        Boton_Comida  = 1'b0;
        Activo_Comida = 1'b1;
        Senal_Test    = 1'b0;
        Senal_MTest   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_nivel", 32'(Nivel_Comida), 32'd3);
        chk("rst_acc", 32'(Comida_Aceptada), 32'd0);
        chk("rst_pulse", 32'(Pulso_Decaimiento), 32'd0);
        chk("rst_espera", 32'(En_Espera), 32'd0);
        reset = 1'b1;

        // Free-running decay: 3->2->1->0 at edges 8,16,24, pulse every 8, floor at 0
        for (int e = 1; e <= 33; e++) begin
            tick();
            chk($sformatf("decay_nivel_e%0d", e), 32'(Nivel_Comida),
                (e >= 24) ? 32'd0 : 32'(3 - e / 8));
            chk($sformatf("decay_pulse_e%0d", e), 32'(Pulso_Decaimiento),
                (e % 8 == 0) ? 32'd1 : 32'd0);
        end

        // Test mode: manual steps wrap, decay frozen, feeding ignored
        Senal_MTest = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press_test();
            chk($sformatf("tstep_nivel_%0d", i), 32'(Nivel_Comida), 32'(exp_steps[i]));
            chk($sformatf("tstep_pulse_%0d", i), 32'(Pulso_Decaimiento), 32'd0);
        end
        Boton_Comida = 1'b1;
        tick();
        Boton_Comida = 1'b0;
        tick();
        tick();
        chk("tmode_feed_acc", 32'(Comida_Aceptada), 32'd0);
        chk("tmode_feed_nivel", 32'(Nivel_Comida), 32'd2);
        chk("tmode_feed_espera", 32'(En_Espera), 32'd0);
        dec_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Pulso_Decaimiento) dec_cnt++;
        end
        chk("tmode_no_decay", 32'(dec_cnt), 32'd0);
        press_test();
        chk("tmode_to_1", 32'(Nivel_Comida), 32'd1);

        // Leave test mode at level 1 and feed on the first normal-mode edge (L)
        Senal_MTest  = 1'b0;
        Boton_Comida = 1'b1;
        tick();                                             // L
        Boton_Comida = 1'b0;
        chk("feed_acc_L", 32'(Comida_Aceptada), 32'd0);
        tick();                                             // L+1
        chk("feed_acc_L1", 32'(Comida_Aceptada), 32'd0);
        tick();                                             // L+2
        chk("feed_acc_L2", 32'(Comida_Aceptada), 32'd1);
        chk("feed_nivel_L2", 32'(Nivel_Comida), 32'd2);
        chk("feed_espera_L2", 32'(En_Espera), 32'd1);
        Boton_Comida = 1'b1;                                // second press inside cooldown
        tick();                                             // L+3
        Boton_Comida = 1'b0;
        chk("feed_acc_L3", 32'(Comida_Aceptada), 32'd0);
        chk("feed_espera_L3", 32'(En_Espera), 32'd1);
        tick();                                             // L+4
        chk("feed_espera_L4", 32'(En_Espera), 32'd1);
        tick();                                             // L+5
        chk("feed_espera_L5", 32'(En_Espera), 32'd1);
        chk("feed_acc_L5", 32'(Comida_Aceptada), 32'd0);
        tick();                                             // L+6
        chk("feed_espera_L6", 32'(En_Espera), 32'd0);
        chk("feed_acc_L6", 32'(Comida_Aceptada), 32'd0);
        chk("feed_nivel_L6", 32'(Nivel_Comida), 32'd2);
        tick();                                             // L+7: decay timer restarted at L
        chk("exit_tmode_pulse", 32'(Pulso_Decaimiento), 32'd1);
        chk("exit_tmode_nivel", 32'(Nivel_Comida), 32'd1);

        // Held button: one accept at L+10, decays at L+15/23/31/39
        Boton_Comida = 1'b1;
        acc_cnt = 0;
        dec_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 29) Boton_Comida = 1'b0;
            if (Comida_Aceptada) acc_cnt++;
            if (Pulso_Decaimiento) dec_cnt++;
        end
        chk("hold_acc_cnt", 32'(acc_cnt), 32'd1);
        chk("hold_dec_cnt", 32'(dec_cnt), 32'd4);
        chk("hold_nivel", 32'(Nivel_Comida), 32'd0);
        tick();
        tick();
        tick();
        Activo_Comida = 1'b0;
        Boton_Comida  = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Comida_Aceptada) acc_cnt++;
        end
        chk("inactive_acc_cnt", 32'(acc_cnt), 32'd0);
        chk("inactive_nivel", 32'(Nivel_Comida), 32'd0);
        chk("inactive_espera", 32'(En_Espera), 32'd0);
        Boton_Comida  = 1'b0;
        Activo_Comida = 1'b1;
        tick();
        tick();
        tick();

        // Accept coincides with decay at level 2: both pulses, level unchanged
        Senal_MTest = 1'b1;
        do_reset();
        press_test();
        chk("coin_setup_nivel", 32'(Nivel_Comida), 32'd2);
        Senal_MTest = 1'b0;
        for (int i = 0; i < 5; i++) tick();                 // L'..L'+4
        Boton_Comida = 1'b1;
        tick();                                             // L'+5
        Boton_Comida = 1'b0;
        tick();                                             // L'+6
        chk("coin_pre_nivel", 32'(Nivel_Comida), 32'd2);
        chk("coin_pre_pulse", 32'(Pulso_Decaimiento), 32'd0);
        tick();                                             // L'+7
        chk("coin_acc", 32'(Comida_Aceptada), 32'd1);
        chk("coin_pulse", 32'(Pulso_Decaimiento), 32'd1);
        chk("coin_nivel", 32'(Nivel_Comida), 32'd2);
        chk("coin_espera", 32'(En_Espera), 32'd1);

        // Reset during cooldown at level 1, then a fresh press is accepted
        Senal_MTest = 1'b1;
        do_reset();
        press_test();
        press_test();
        press_test();
        chk("rcool_setup_nivel", 32'(Nivel_Comida), 32'd0);
        Senal_MTest  = 1'b0;
        Boton_Comida = 1'b1;
        tick();
        Boton_Comida = 1'b0;
        tick();
        tick();
        chk("rcool_acc", 32'(Comida_Aceptada), 32'd1);
        chk("rcool_nivel", 32'(Nivel_Comida), 32'd1);
        chk("rcool_espera", 32'(En_Espera), 32'd1);
        tick();
        chk("rcool_espera2", 32'(En_Espera), 32'd1);
        reset = 1'b0;
        tick();
        chk("rcool_rst_nivel", 32'(Nivel_Comida), 32'd3);
        chk("rcool_rst_espera", 32'(En_Espera), 32'd0);
        chk("rcool_rst_acc", 32'(Comida_Aceptada), 32'd0);
        chk("rcool_rst_pulse", 32'(Pulso_Decaimiento), 32'd0);
        reset        = 1'b1;
        Boton_Comida = 1'b1;
        tick();
        Boton_Comida = 1'b0;
        tick();
        chk("fresh_acc_early", 32'(Comida_Aceptada), 32'd0);
        tick();
        chk("fresh_acc", 32'(Comida_Aceptada), 32'd1);
        chk("fresh_nivel", 32'(Nivel_Comida), 32'd3);
        chk("fresh_espera", 32'(En_Espera), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
